// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts one clipped rectangle command at a time and
// streams one framebuffer write per clock in raster order.
module fb_rect_fill #(
    parameter int FB_X = 1280,
    parameter int FB_Y = 720,
    localparam int X_BITS    = $clog2(FB_X),
    localparam int Y_BITS    = $clog2(FB_Y),
    localparam int W_BITS    = $clog2(FB_X + 1),
    localparam int H_BITS    = $clog2(FB_Y + 1),
    localparam int ADDR_BITS = $clog2(FB_X * FB_Y)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [X_BITS-1:0]    cmd_x_i,
    input  logic [Y_BITS-1:0]    cmd_y_i,
    input  logic [W_BITS-1:0]    cmd_w_i,
    input  logic [H_BITS-1:0]    cmd_h_i,
    input  logic [23:0]          cmd_color_i,
    output logic [ADDR_BITS-1:0] pxl_addr_o,
    output logic [23:0]          pxl_data_o,
    output logic                 pxl_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           dbg_state_o
);

    // Handshake: a command transfers on a rising clk_i edge where
    // cmd_valid_i && cmd_ready_o; the caller holds cmd_* stable until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLIP = 2'd1,
        S_FILL = 2'd2
    } state_t;

    localparam logic [W_BITS:0]      FB_X_W = (W_BITS + 1)'(FB_X);
    localparam logic [H_BITS:0]      FB_Y_H = (H_BITS + 1)'(FB_Y);
    localparam logic [ADDR_BITS-1:0] FB_X_A = ADDR_BITS'(FB_X);
    localparam logic [W_BITS:0]      COL_ONE = (W_BITS + 1)'(1);
    localparam logic [H_BITS:0]      ROW_ONE = (H_BITS + 1)'(1);

    state_t state_q, state_d;

    logic [X_BITS-1:0]    x_q;
    logic [Y_BITS-1:0]    y_q;
    logic [W_BITS-1:0]    w_q;
    logic [H_BITS-1:0]    h_q;
    logic [23:0]          color_q;
    logic [W_BITS:0]      w_eff_q, col_q;
    logic [H_BITS:0]      h_eff_q, row_q;
    logic [ADDR_BITS-1:0] row_start_q;

    logic [W_BITS:0]      x_ext, w_ext, rem_x, w_eff_c;
    logic [H_BITS:0]      y_ext, h_ext, rem_y, h_eff_c;
    logic [ADDR_BITS-1:0] start_c;
    logic                 empty_c, row_end_c, last_c;

    // Clipping arithmetic runs one bit wider than the size fields so that
    // FB - x never wraps; start_c is only consumed when the command is non-empty.
    always_comb begin
        x_ext     = (W_BITS + 1)'(x_q);
        y_ext     = (H_BITS + 1)'(y_q);
        w_ext     = (W_BITS + 1)'(w_q);
        h_ext     = (H_BITS + 1)'(h_q);
        empty_c   = (x_ext >= FB_X_W) || (y_ext >= FB_Y_H) || (w_q == '0) || (h_q == '0);
        rem_x     = FB_X_W - x_ext;
        rem_y     = FB_Y_H - y_ext;
        w_eff_c   = (w_ext < rem_x) ? w_ext : rem_x;
        h_eff_c   = (h_ext < rem_y) ? h_ext : rem_y;
        start_c   = ADDR_BITS'(y_q) * FB_X_A + ADDR_BITS'(x_q);
        row_end_c = (col_q + COL_ONE) == w_eff_q;
        last_c    = row_end_c && ((row_q + ROW_ONE) == h_eff_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i) state_d = S_CLIP;
            S_CLIP:  state_d = empty_c ? S_IDLE : S_FILL;
            S_FILL:  if (last_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        busy_o      = !cmd_ready_o;
        dbg_state_o = state_q;
    end

    // col_q/row_q always describe the write currently on the pxl_* port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            w_eff_q     <= '0;
            h_eff_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_start_q <= '0;
            pxl_addr_o  <= '0;
            pxl_data_o  <= '0;
            pxl_en_o    <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        x_q     <= cmd_x_i;
                        y_q     <= cmd_y_i;
                        w_q     <= cmd_w_i;
                        h_q     <= cmd_h_i;
                        color_q <= cmd_color_i;
                    end
                end
                S_CLIP: begin
                    if (empty_c) begin
                        done_o <= 1'b1;
                    end else begin
                        w_eff_q     <= w_eff_c;
                        h_eff_q     <= h_eff_c;
                        col_q       <= '0;
                        row_q       <= '0;
                        row_start_q <= start_c;
                        pxl_addr_o  <= start_c;
                        pxl_data_o  <= color_q;
                        pxl_en_o    <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (last_c) begin
                        pxl_en_o <= 1'b0;
                        done_o   <= 1'b1;
                    end else if (row_end_c) begin
                        col_q       <= '0;
                        row_q       <= row_q + ROW_ONE;
                        row_start_q <= row_start_q + FB_X_A;
                        pxl_addr_o  <= row_start_q + FB_X_A;
                    end else begin
                        col_q      <= col_q + COL_ONE;
                        pxl_addr_o <= pxl_addr_o + ADDR_BITS'(1);
                    end
                end
                default: pxl_en_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: a 16x8 instance checked by a cycle-stamped write
// scoreboard, plus a 12x6 instance for out-of-range origins and odd bounds.
module tb_fb_rect_fill;

    localparam int FBX = 16, FBY = 8;
    localparam int XB = 4, YB = 3, WB = 5, HB = 4, AB = 7;
    localparam int BX = 12, BY = 6;
    localparam int BWB = 4, BHB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready;
    logic [XB-1:0] cmd_x = '0;
    logic [YB-1:0] cmd_y = '0;
    logic [WB-1:0] cmd_w = '0;
    logic [HB-1:0] cmd_h = '0;
    logic [23:0]   cmd_color = '0;
    logic [AB-1:0] pxl_addr;
    logic [23:0]   pxl_data;
    logic          pxl_en, busy, done;
    logic [1:0]    dbg_state;

    logic           b_valid = 1'b0, b_ready;
    logic [3:0]     b_x = '0;
    logic [2:0]     b_y = '0;
    logic [BWB-1:0] b_w = '0;
    logic [BHB-1:0] b_h = '0;
    logic [23:0]    b_color = '0;
    logic [6:0]     b_addr;
    logic [23:0]    b_data;
    logic           b_en, b_busy, b_done;
    logic [1:0]     b_dbg_state;

    fb_rect_fill #(.FB_X(FBX), .FB_Y(FBY)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
        .cmd_color_i(cmd_color),
        .pxl_addr_o(pxl_addr), .pxl_data_o(pxl_data), .pxl_en_o(pxl_en),
        .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state)
    );

    fb_rect_fill #(.FB_X(BX), .FB_Y(BY)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(b_valid), .cmd_ready_o(b_ready),
        .cmd_x_i(b_x), .cmd_y_i(b_y), .cmd_w_i(b_w), .cmd_h_i(b_h),
        .cmd_color_i(b_color),
        .pxl_addr_o(b_addr), .pxl_data_o(b_data), .pxl_en_o(b_en),
        .busy_o(b_busy), .done_o(b_done), .dbg_state_o(b_dbg_state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_seen = 0;
    logic [55:0] exp_q[$];
    int          done_q[$];

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: expected writes {cycle, addr, data} and done cycle.
    task automatic model_push(input int x, input int y, input int w, input int h,
                              input logic [23:0] c, input int n);
        int we, he;
        if (x >= FBX || y >= FBY || w == 0 || h == 0) begin
            done_q.push_back(n + 2);
        end else begin
            we = (w < FBX - x) ? w : FBX - x;
            he = (h < FBY - y) ? h : FBY - y;
            for (int r = 0; r < he; r++)
                for (int k = 0; k < we; k++)
                    exp_q.push_back({24'(n + 2 + r * we + k), 1'b0, 7'((y + r) * FBX + x + k), c});
            done_q.push_back(n + 2 + we * he);
        end
    endtask

    always @(negedge clk) begin
        logic [55:0] e, a;
        int d;
        if (!rst_n) begin
            exp_q.delete();
            done_q.delete();
        end else begin
            total++;
            if (busy !== !cmd_ready) begin
                bad++;
                $display("FAIL busy_vs_ready cyc=%0d busy=%b ready=%b", cyc, busy, cmd_ready);
            end
            if (cmd_valid && cmd_ready)
                model_push(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), cmd_color, cyc);
            if (pxl_en === 1'b1) begin
                wr_seen++;
                total++;
                a = {24'(cyc), 1'b0, pxl_addr, pxl_data};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, pxl_addr, pxl_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL write got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                                 cyc, pxl_addr, pxl_data, e[55:32], e[30:24], e[23:0]);
                    end
                end
            end
            if (done === 1'b1) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d", cyc);
                end else begin
                    d = done_q.pop_front();
                    if (cyc != d) begin
                        bad++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, d);
                    end
                end
            end
        end
    end

    // Drive a command during the current cycle; n returns its handshake cycle.
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [23:0] c, output int n);
        cmd_x = x[XB-1:0];
        cmd_y = y[YB-1:0];
        cmd_w = w[WB-1:0];
        cmd_h = h[HB-1:0];
        cmd_color = c;
        cmd_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout x=%0d y=%0d", x, y);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0 && cmd_ready) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (ok == 0) begin
            bad++;
            $display("FAIL drain_timeout pending_writes=%0d pending_done=%0d", exp_q.size(), done_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'($urandom);
            cmd_x = 4'($urandom);
            cmd_y = 3'($urandom);
            cmd_w = 5'($urandom);
            cmd_h = 4'($urandom);
            cmd_color = 24'($urandom);
            @(negedge clk);
            total++;
            if (pxl_en !== 1'b0 || done !== 1'b0 || pxl_addr !== '0 || pxl_data !== '0 ||
                cmd_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_values en=%b done=%b addr=%0d data=%h ready=%b busy=%b",
                         pxl_en, done, pxl_addr, pxl_data, cmd_ready, busy);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        wr_seen = 0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (wr_seen != 0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset writes=%0d ready=%b", wr_seen, cmd_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        send_cmd(3, 1, 2, 2, 24'h123456, n);
        wait_idle(20);
    endtask

    task automatic test_clip();
        int n;
        send_cmd(14, 6, 5, 5, 24'hABCDEF, n);
        wait_idle(20);
        send_cmd(0, 0, 16, 8, 24'h00FF00, n);
        wait_idle(300);
        send_cmd(15, 0, 31, 15, 24'h0F0F0F, n);
        wait_idle(40);
    endtask

    task automatic test_empty();
        int n;
        int cmds[2][4] = '{'{2, 3, 0, 4}, '{5, 1, 3, 0}};
        for (int i = 0; i < 2; i++) begin
            send_cmd(cmds[i][0], cmds[i][1], cmds[i][2], cmds[i][3], 24'h777777, n);
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL empty_ready_clip cmd=%0d got=%b exp=0", i, cmd_ready);
            end
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b1 || done !== 1'b1) begin
                bad++;
                $display("FAIL empty_retire cmd=%0d ready=%b done=%b exp 1/1", i, cmd_ready, done);
            end
            wait_idle(10);
        end
    endtask

    task automatic test_back_to_back();
        int na, nb;
        send_cmd(5, 2, 1, 1, 24'hA0A0A0, na);
        send_cmd(1, 4, 3, 2, 24'h0B0B0B, nb);
        total++;
        if (nb != na + 3) begin
            bad++;
            $display("FAIL b2b_accept got=%0d exp=%0d", nb, na + 3);
        end
        wait_idle(30);
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 8; i++) begin
            send_cmd($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 20),
                     $urandom_range(0, 10), 24'($urandom), n);
            wait_idle(300);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        send_cmd(2, 2, 4, 4, 24'hDEAD00, n);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (pxl_en !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset en=%b done=%b ready=%b exp 0/0/1", pxl_en, done, cmd_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send_cmd(0, 0, 1, 1, 24'h0000C3, n);
        wait_idle(20);
    endtask

    // Out-of-range origins on a 12x6 instance, where x=12..15 / y=6,7 are encodable.
    task automatic run_b(input int x, input int y, input int w, input int h,
                         input int cnt, input int a0, input int a1, input int a2,
                         input int a3, input int done_off);
        int ea[4];
        int k, n;
        logic en_exp;
        ea = '{a0, a1, a2, a3};
        b_x = x[3:0];
        b_y = y[2:0];
        b_w = w[BWB-1:0];
        b_h = h[BHB-1:0];
        b_color = 24'hA50F3C;
        b_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_ready) begin
                n = cyc;
                break;
            end
        end
        @(posedge clk);
        #1 b_valid = 1'b0;
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL b_handshake_timeout x=%0d y=%0d", x, y);
        end else begin
            for (int c = 1; c <= done_off + 1; c++) begin
                @(negedge clk);
                k = c - 2;
                en_exp = (k >= 0 && k < cnt);
                total++;
                if (b_en !== en_exp) begin
                    bad++;
                    $display("FAIL b_en x=%0d y=%0d off=%0d got=%b exp=%b", x, y, c, b_en, en_exp);
                end
                if (en_exp) begin
                    total++;
                    if (b_addr !== 7'(ea[k]) || b_data !== 24'hA50F3C) begin
                        bad++;
                        $display("FAIL b_write off=%0d addr=%0d exp=%0d data=%h", c, b_addr, ea[k], b_data);
                    end
                end
                total++;
                if (b_done !== (c == done_off)) begin
                    bad++;
                    $display("FAIL b_done x=%0d y=%0d off=%0d got=%b", x, y, c, b_done);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_odd_bounds();
        run_b(12, 0, 2, 2, 0, 0, 0, 0, 0, 2);
        run_b(15, 1, 2, 2, 0, 0, 0, 0, 0, 2);
        run_b(0, 6, 2, 2, 0, 0, 0, 0, 0, 2);
        run_b(0, 7, 2, 2, 0, 0, 0, 0, 0, 2);
        run_b(10, 4, 5, 5, 4, 58, 59, 70, 71, 6);
        run_b(11, 5, 3, 3, 1, 71, 0, 0, 0, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        test_odd_bounds();
        total++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL leftover writes=%0d dones=%0d", exp_q.size(), done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
